alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the processor's 8-bit combinational ALU. It executes one operation per START request on WIDTH-bit signed operands and registers the result, a zero flag and an overflow flag. Single-cycle ops finish in one clock. Iterative ops (shift-add multiply, arithmetic right shift) hold BUSY until done. It sits between the register file read ports and the write-back path, and the control unit stalls on BUSY.

---
 rtl/alu_seq.sv | 155 +++++++++++++++
 tb/tb_alu_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle signed ALU: single-cycle FORWARD/ADD/AND/OR/SUB, iterative SRA and
// (when ALU_SEQ_MULT_EN is defined) iterative shift-add MULT; registered RESULT/ZERO/OVF.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd2;
`ifdef ALU_SEQ_MULT_EN
  localparam logic [1:0] S_MUL   = 2'd1;
`endif

  // Counter must hold both WIDTH (multiply) and the largest shift amount.
  localparam int CW = (SHW + 1 > $clog2(WIDTH + 1)) ? SHW + 1 : $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_next;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_result;
  logic             sc_ovf;

`ifdef ALU_SEQ_MULT_EN
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_next;

  assign acc_next = mplier[0] ? acc + mcand : acc;
`endif

  assign busy    = (state != S_IDLE);
  assign sum     = data1 + data2;
  assign diff    = data1 - data2;
  assign shamt   = data2[SHW-1:0];
  assign sh_next = {sh[WIDTH-1], sh[WIDTH-1:1]};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sc_result = '0;
    sc_ovf    = 1'b0;
    case (select)
      OP_FWD: sc_result = data2;
      OP_ADD: begin
        sc_result = sum;
        sc_ovf    = (data1[WIDTH-1] == data2[WIDTH-1]) && (sum[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_AND: sc_result = data1 & data2;
      OP_OR:  sc_result = data1 | data2;
      OP_SRA: sc_result = data1;  // only reached for a zero shift amount
      OP_SUB: begin
        sc_result = diff;
        sc_ovf    = (data1[WIDTH-1] != data2[WIDTH-1]) && (diff[WIDTH-1] != data1[WIDTH-1]);
      end
      default: sc_result = '0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      sh     <= '0;
      result <= '0;
      zero   <= 1'b1;
      ovf    <= 1'b0;
      done   <= 1'b0;
`ifdef ALU_SEQ_MULT_EN
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
`ifdef ALU_SEQ_MULT_EN
            if (select == OP_MUL) begin
              state  <= S_MUL;
              cnt    <= CW'(WIDTH);
              acc    <= '0;
              mcand  <= data1;
              mplier <= data2;
            end else
`endif
            if (select == OP_SRA && shamt != '0) begin
              state <= S_SHIFT;
              cnt   <= CW'(shamt);
              sh    <= data1;
            end else begin
              result <= sc_result;
              zero   <= (sc_result == '0);
              ovf    <= sc_ovf;
              done   <= 1'b1;
            end
          end
        end
`ifdef ALU_SEQ_MULT_EN
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result <= acc_next;
            zero   <= (acc_next == '0);
            ovf    <= 1'b0;
            done   <= 1'b1;
            state  <= S_IDLE;
          end
        end
`endif
        S_SHIFT: begin
          sh  <= sh_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result <= sh_next;
            zero   <= (sh_next == '0);
            ovf    <= 1'b0;
            done   <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): stimulus pushes expected responses with due
// cycles; a monitor checks DONE timing, BUSY and result fields against an arithmetic model.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   select;
  logic [W-1:0] data1;
  logic [W-1:0] data2;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;
  logic         busy;
  logic         done;

  alu_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .select (select),
    .data1  (data1),
    .data2  (data2),
    .result (result),
    .zero   (zero),
    .ovf    (ovf),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         o;
    int           due;
  } exp_t;

  exp_t q[$];
  int   cyc       = 0;
  int   busy_from = 0;
  int   busy_to   = -1;
  int   tests     = 0;
  int   fails     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain signed integer arithmetic, truncated to W bits.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output int iter);
    exp_t e;
    int sa, sb, r, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = 0;
    iter = 0;
    e.o = 1'b0;
    case (op)
      3'd0: r = sb;
      3'd1: begin r = sa + sb; e.o = (r > 127) || (r < -128); end
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
`ifdef ALU_SEQ_MULT_EN
      3'd4: begin r = sa * sb; iter = W; end
`else
      3'd4: r = 0;
`endif
      3'd5: begin s = int'(b) % W; r = sa >>> s; iter = s; end
      3'd6: begin r = sa - sb; e.o = (r > 127) || (r < -128); end
      default: r = 0;
    endcase
    e.res = r[W-1:0];
    e.z   = (e.res == 0);
    e.due = 0;
    return e;
  endfunction

  // Called at a negedge with busy low; START is accepted on the next edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   iter;
    int   k;
    start  = 1'b1;
    select = op;
    data1  = a;
    data2  = b;
    e = model(op, a, b, iter);
    k = cyc + 1;
    e.due = k + iter;
    q.push_back(e);
    if (iter > 0) begin
      busy_from = k;
      busy_to   = k + iter - 1;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: samples shortly after each active edge.
  initial begin
    exp_t e;
    bit   exp_done;
    forever begin
      @(posedge clk);
      #2;
      check("busy", {31'd0, busy}, {31'd0, (cyc >= busy_from && cyc <= busy_to)});
      exp_done = (q.size() > 0) && (q[0].due == cyc);
      check("done", {31'd0, done}, {31'd0, exp_done});
      if (exp_done) begin
        e = q.pop_front();
        if (done) begin
          check("result", {24'd0, result}, {24'd0, e.res});
          check("zero",   {31'd0, zero},   {31'd0, e.z});
          check("ovf",    {31'd0, ovf},    {31'd0, e.o});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    reset  = 1'b1;
    start  = 1'b0;
    select = '0;
    data1  = '0;
    data2  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_result", {24'd0, result}, 32'd0);
    check("reset_zero",   {31'd0, zero},   32'd1);
    check("reset_ovf",    {31'd0, ovf},    32'd0);

    // Directed cases from the block's intended use.
    issue(3'b000, 8'd0, 8'd65);          wait_idle();
    issue(3'b001, 8'd100, 8'd50);        wait_idle();
    issue(3'b110, 8'd5, 8'd5);           wait_idle();
    issue(3'b010, 8'b00100110, 8'b00111010);
    issue(3'b011, 8'h0F, 8'hA0);         // back-to-back single-cycle ops
    issue(3'b110, 8'h80, 8'h01);         wait_idle();
    issue(3'b101, 8'h80, 8'd3);          wait_idle();
    issue(3'b101, 8'h80, 8'd0);          wait_idle();
    issue(3'b111, 8'h12, 8'h34);         wait_idle();
    issue(3'b100, 8'd3, 8'd4);           wait_idle();

    // Iterative op with an ignored START mid-operation.
`ifdef ALU_SEQ_MULT_EN
    issue(3'b100, 8'hFD, 8'd7);
`else
    issue(3'b101, 8'hC4, 8'd6);
`endif
    @(negedge clk);
    start = 1'b1; select = 3'b001; data1 = 8'd1; data2 = 8'd2;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset on the 4th busy cycle aborts the operation with no DONE.
`ifdef ALU_SEQ_MULT_EN
    issue(3'b100, 8'd12, 8'd12);
`else
    issue(3'b101, 8'h80, 8'd7);
`endif
    repeat (3) @(negedge clk);
    reset = 1'b1;
    q.delete();
    busy_to = cyc;
    @(negedge clk);
    check("abort_result", {24'd0, result}, 32'd0);
    check("abort_zero",   {31'd0, zero},   32'd1);
    check("abort_ovf",    {31'd0, ovf},    32'd0);
    check("abort_done",   {31'd0, done},   32'd0);
    reset = 1'b0;
    issue(3'b001, 8'd1, 8'd1);           wait_idle();

    // Randomized traffic, sometimes poking START while busy.
    for (int i = 0; i < 120; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      issue(op, a, b);
      if (busy && $urandom_range(0, 2) == 0) begin
        start = 1'b1; select = 3'($urandom); data1 = 8'($urandom); data2 = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
      end
      wait_idle();
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
